// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one synchronous RAM between a CPU and a video reader.
// CPU has priority; a saturating starve counter forces a video slot after STARVE_LIMIT losses.
module mem_arbiter #(
  parameter logic [11:0] SCREEN_BASE  = 12'h100,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [11:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  input  logic        vid_req,
  input  logic [7:0]  vid_addr,
  output logic        vid_ack,
  output logic [7:0]  vid_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic       r_cpu_ack;
  logic       r_vid_ack;
  logic       r_cpu_rd;
  logic [7:0] r_cpu_rdata;
  logic [7:0] r_vid_rdata;
  logic [3:0] r_starve;

  logic        w_cpu_elig;
  logic        w_vid_elig;
  logic        w_cpu_win;
  logic        w_vid_win;
  logic [11:0] w_vid_mem_addr;

  // A port with its ack due this cycle is still in flight and may not be granted again.
  assign w_cpu_elig     = cpu_req & ~r_cpu_ack & ~reset;
  assign w_vid_elig     = vid_req & ~r_vid_ack & ~reset;
  assign w_vid_win      = w_vid_elig & (~w_cpu_elig | (r_starve == LIMIT));
  assign w_cpu_win      = w_cpu_elig & ~w_vid_win;
  assign w_vid_mem_addr = SCREEN_BASE + {4'h0, vid_addr};

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 12'h000;
    mem_wdata = 8'h00;
    if (w_cpu_win) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (w_vid_win) begin
      mem_en    = 1'b1;
      mem_addr  = w_vid_mem_addr;
    end
  end

  assign cpu_ack   = r_cpu_ack;
  assign vid_ack   = r_vid_ack;
  // RAM data arrives in the ack cycle; pass it through then, otherwise show the held copy.
  assign cpu_rdata = (r_cpu_ack & r_cpu_rd) ? mem_rdata : r_cpu_rdata;
  assign vid_rdata = r_vid_ack ? mem_rdata : r_vid_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cpu_ack   <= 1'b0;
      r_vid_ack   <= 1'b0;
      r_cpu_rd    <= 1'b0;
      r_cpu_rdata <= 8'h00;
      r_vid_rdata <= 8'h00;
      r_starve    <= 4'h0;
    end else begin
      r_cpu_ack <= w_cpu_win;
      r_vid_ack <= w_vid_win;
      if (w_cpu_win)
        r_cpu_rd <= ~cpu_we;
      if (r_cpu_ack & r_cpu_rd)
        r_cpu_rdata <= mem_rdata;
      if (r_vid_ack)
        r_vid_rdata <= mem_rdata;
      if (w_vid_win)
        r_starve <= 4'h0;
      else if (w_vid_elig && (r_starve < LIMIT))
        r_starve <= r_starve + 4'h1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grant/ack timing, read data, priority, starvation, wrap, reset.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        vid_req;
  logic [7:0]  vid_addr;
  logic        vid_ack;
  logic [7:0]  vid_rdata;
  logic        mem_en, mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic        u1_cpu_ack, u1_vid_ack, u1_mem_en, u1_mem_we;
  logic [7:0]  u1_cpu_rdata, u1_vid_rdata, u1_mem_wdata;
  logic [11:0] u1_mem_addr;
  logic [7:0]  u1_mem_rdata = 8'h00;

  logic [7:0]  ram [0:4095];
  int          n_assert = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.SCREEN_BASE(12'hFF0)) u1 (
    .clk(clk), .reset(reset),
    .cpu_req(1'b0), .cpu_we(1'b0), .cpu_addr(12'h000), .cpu_wdata(8'h00),
    .cpu_ack(u1_cpu_ack), .cpu_rdata(u1_cpu_rdata),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(u1_vid_ack), .vid_rdata(u1_vid_rdata),
    .mem_en(u1_mem_en), .mem_we(u1_mem_we), .mem_addr(u1_mem_addr), .mem_wdata(u1_mem_wdata),
    .mem_rdata(u1_mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h123; cpu_wdata = 8'h77;
    vid_req = 1'b0; vid_addr = 8'h00;
    #3;
    chk("rst_cpu_ack", 16'(cpu_ack), 16'h0);
    chk("rst_vid_ack", 16'(vid_ack), 16'h0);
    chk("rst_cpu_rdata", 16'(cpu_rdata), 16'h0);
    chk("rst_vid_rdata", 16'(vid_rdata), 16'h0);
    chk("rst_mem_en", 16'(mem_en), 16'h0);
    chk("rst_mem_we", 16'(mem_we), 16'h0);
    chk("rst_mem_addr", 16'(mem_addr), 16'h0);
    chk("rst_mem_wdata", 16'(mem_wdata), 16'h0);
    cyc();
    reset = 1'b0;

    // CPU writes 105<-A5 and 020<-42, then reads 020
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h105; cpu_wdata = 8'hA5;
    settle();
    chk("wr1_mem_en", 16'(mem_en), 16'h1);
    chk("wr1_mem_we", 16'(mem_we), 16'h1);
    chk("wr1_mem_addr", 16'(mem_addr), 16'h105);
    chk("wr1_mem_wdata", 16'(mem_wdata), 16'hA5);
    chk("wr1_no_ack", 16'(cpu_ack), 16'h0);
    cyc(); cpu_req = 1'b0; settle();
    chk("wr1_ack", 16'(cpu_ack), 16'h1);
    chk("wr1_rdata_kept", 16'(cpu_rdata), 16'h0);
    chk("wr1_ack_idle", 16'(mem_en), 16'h0);
    cyc(); cpu_req = 1'b1; cpu_addr = 12'h020; cpu_wdata = 8'h42; settle();
    chk("wr2_mem_addr", 16'(mem_addr), 16'h020);
    chk("wr2_mem_wdata", 16'(mem_wdata), 16'h42);
    cyc(); cpu_req = 1'b0; settle();
    chk("wr2_ack", 16'(cpu_ack), 16'h1);
    cyc(); cpu_req = 1'b1; cpu_we = 1'b0; settle();
    chk("rd_mem_we", 16'(mem_we), 16'h0);
    chk("rd_mem_addr", 16'(mem_addr), 16'h020);
    chk("rd_no_ack", 16'(cpu_ack), 16'h0);
    cyc(); cpu_req = 1'b0; settle();
    chk("rd_ack", 16'(cpu_ack), 16'h1);
    chk("rd_rdata", 16'(cpu_rdata), 16'h42);
    cyc(); settle();
    chk("rd_ack_done", 16'(cpu_ack), 16'h0);
    chk("rd_rdata_held", 16'(cpu_rdata), 16'h42);

    // video read at offset 05, and screen-base wrap on the second instance
    vid_req = 1'b1; vid_addr = 8'h05; settle();
    chk("vid_mem_en", 16'(mem_en), 16'h1);
    chk("vid_mem_we", 16'(mem_we), 16'h0);
    chk("vid_mem_addr", 16'(mem_addr), 16'h105);
    chk("vid_mem_wdata", 16'(mem_wdata), 16'h0);
    chk("u1_mem_addr_ff5", 16'(u1_mem_addr), 16'hFF5);
    cyc(); vid_req = 1'b0; settle();
    chk("vid_ack", 16'(vid_ack), 16'h1);
    chk("vid_rdata", 16'(vid_rdata), 16'hA5);
    chk("vid_ack_idle", 16'(mem_en), 16'h0);
    cyc(); vid_req = 1'b1; vid_addr = 8'h20; settle();
    chk("wrap_u1_addr", 16'(u1_mem_addr), 16'h010);
    chk("wrap_u0_addr", 16'(mem_addr), 16'h120);
    cyc(); vid_req = 1'b0;
    cyc();

    // both requesters held: strict CPU/video interleave
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h020; vid_req = 1'b1; vid_addr = 8'h05;
    for (int i = 0; i < 6; i++) begin
      settle();
      chk($sformatf("il_addr_%0d", i), 16'(mem_addr), (i % 2 == 0) ? 16'h020 : 16'h105);
      chk($sformatf("il_cpu_ack_%0d", i), 16'(cpu_ack), (i % 2 == 1) ? 16'h1 : 16'h0);
      chk($sformatf("il_vid_ack_%0d", i), 16'(vid_ack), (i >= 2 && i % 2 == 0) ? 16'h1 : 16'h0);
      if (i % 2 == 1) chk($sformatf("il_cpu_rdata_%0d", i), 16'(cpu_rdata), 16'h42);
      if (i >= 2 && i % 2 == 0) chk($sformatf("il_vid_rdata_%0d", i), 16'(vid_rdata), 16'hA5);
      cyc();
    end
    cpu_req = 1'b0; vid_req = 1'b0; settle();
    chk("il_last_vid_ack", 16'(vid_ack), 16'h1);
    chk("il_last_cpu_ack", 16'(cpu_ack), 16'h0);
    cyc();

    // starvation: video asks only in CPU grant cycles, wins on its 5th eligible cycle
    cpu_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      vid_req = (k % 2 == 0) ? 1'b1 : 1'b0;
      settle();
      chk($sformatf("st_en_%0d", k), 16'(mem_en), (k % 2 == 0 || k == 9) ? 16'h1 : 16'h0);
      if (k % 2 == 0 || k == 9)
        chk($sformatf("st_addr_%0d", k), 16'(mem_addr), (k == 8) ? 16'h105 : 16'h020);
      chk($sformatf("st_cpu_ack_%0d", k), 16'(cpu_ack), (k % 2 == 1 && k < 9) ? 16'h1 : 16'h0);
      chk($sformatf("st_vid_ack_%0d", k), 16'(vid_ack), (k == 9) ? 16'h1 : 16'h0);
      cyc();
    end
    cpu_req = 1'b0; vid_req = 1'b0; settle();
    chk("st_final_cpu_ack", 16'(cpu_ack), 16'h1);
    chk("st_final_idle", 16'(mem_en), 16'h0);
    cyc();
    cpu_req = 1'b1; vid_req = 1'b1; settle();
    chk("st_cleared_cpu_wins", 16'(mem_addr), 16'h020);
    cyc(); cpu_req = 1'b0; settle();
    chk("st_cleared_vid_next", 16'(mem_addr), 16'h105);
    cyc(); vid_req = 1'b0; settle();
    chk("st_cleared_vid_ack", 16'(vid_ack), 16'h1);
    cyc();

    // reset in the ack cycle of a CPU read discards the access
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h020; settle();
    chk("rr_grant", 16'(mem_en), 16'h1);
    cyc(); reset = 1'b1; cpu_req = 1'b0; settle();
    chk("rr_cpu_ack", 16'(cpu_ack), 16'h0);
    chk("rr_cpu_rdata", 16'(cpu_rdata), 16'h0);
    chk("rr_vid_rdata", 16'(vid_rdata), 16'h0);
    chk("rr_mem_en", 16'(mem_en), 16'h0);
    chk("rr_mem_addr", 16'(mem_addr), 16'h0);
    cyc(); reset = 1'b0; settle();
    chk("rr_no_late_ack", 16'(cpu_ack), 16'h0);
    cpu_req = 1'b1; settle();
    chk("rr_regrant", 16'(mem_en), 16'h1);
    chk("rr_regrant_addr", 16'(mem_addr), 16'h020);
    cyc(); cpu_req = 1'b0; settle();
    chk("rr_ack", 16'(cpu_ack), 16'h1);
    chk("rr_rdata", 16'(cpu_rdata), 16'h42);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter SCREEN_BASE, default 12'h100: base address of the 256-byte screen buffer.
REQ-002 Parameter STARVE_LIMIT, default 4: consecutive video losses before video is forced a slot (range 1..15).
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 cpu_req  input  1  CPU access request; held until cpu_ack.
REQ-006 cpu_we  input  1  1 = write, 0 = read; stable while cpu_req is high.
REQ-007 cpu_addr  input  12  CPU byte address.
REQ-008 cpu_wdata  input  8  CPU write data.
REQ-009 cpu_ack  output  1  one-cycle pulse; access complete.
REQ-010 cpu_rdata  output  8  CPU read data; valid in the cpu_ack cycle of a read.
REQ-011 vid_req  input  1  video read request; held until vid_ack.
REQ-012 vid_addr  input  8  byte offset into screen buffer.
REQ-013 vid_ack  output  1  one-cycle pulse; read complete.
REQ-014 vid_rdata  output  8  video read data; valid in the vid_ack cycle.
REQ-015 mem_en  output  1  RAM access strobe this cycle.
REQ-016 mem_we  output  1  RAM write enable, qualified by mem_en.
REQ-017 mem_addr  output  12  RAM address.
REQ-018 mem_wdata  output  8  RAM write data.
REQ-019 mem_rdata  input  8  synchronous RAM read data, valid one cycle after mem_en.

Function
REQ-020 The block SHALL issue at most one RAM access per cycle; mem_en/mem_we/mem_addr/mem_wdata are combinational from the current-cycle grant.
REQ-021 A port is eligible when its req is high and it has no access in flight (its ack not due this cycle).
REQ-022 Both eligible: CPU wins, unless starve counter == STARVE_LIMIT, then video wins.
REQ-023 Only one eligible: that port wins; none eligible: mem_en = 0, mem_we = 0.
REQ-024 CPU grant: mem_addr = cpu_addr, mem_we = cpu_we, mem_wdata = cpu_wdata.
REQ-025 Video grant: mem_addr = SCREEN_BASE + vid_addr, modulo 4096 (12-bit wrap); mem_we = 0; mem_wdata = 0.
REQ-026 Latency: ack SHALL pulse exactly one cycle after the grant cycle; for reads, rdata is registered from mem_rdata and held until the next read completion on that port.
REQ-027 CPU writes SHALL ack with the same latency and leave cpu_rdata unchanged.
REQ-028 A port SHALL be granted at most once per two cycles; grants of the other port may fill the ack cycle (back-to-back interleaving: CPU, video, CPU, ...).
REQ-029 Starve counter (4 bits): increments, saturating at STARVE_LIMIT, each cycle video is eligible and not granted; clears to 0 on every video grant; holds when video not eligible.
REQ-030 Requester dropping req before ack (protocol violation): access already granted still completes and acks; no new grant is made.
REQ-031 req held high through and after its ack cycle is a new request, eligible the cycle after ack.

Reset
REQ-032 While reset is high: cpu_ack = 0, vid_ack = 0, cpu_rdata = 0, vid_rdata = 0, mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, starve counter = 0, in-flight flags cleared.
REQ-033 Reset asserted with an access in flight SHALL discard it: no ack is produced after reset deasserts.
REQ-034 First grant may occur in the first rising edge cycle after reset deasserts.

Verification
REQ-035 CPU write 12'h020 <- 8'h42, then CPU read 12'h020 -> second cpu_ack carries cpu_rdata = 8'h42; ack 1 cycle after each grant.
REQ-036 Video read vid_addr = 8'h05 with RAM[12'h105] = 8'hA5 -> mem_addr = 12'h105, mem_we = 0, vid_ack next cycle, vid_rdata = 8'hA5.
REQ-037 Both req held continuously, STARVE_LIMIT = 4 -> grant sequence interleaves CPU/video every cycle (video eligible only in CPU ack cycles), never two video losses on an idle CPU slot; counter never exceeds 4.
REQ-038 Starvation: CPU eligible every cycle via alternate masters model (cpu_req re-asserted, video offset ack windows aligned to CPU grants) -> video granted no later than its 5th eligible cycle, counter then 0.
REQ-039 SCREEN_BASE = 12'hFF0, vid_addr = 8'h20 -> mem_addr = 12'h010 (wrap).
REQ-040 Reset pulsed the cycle after a CPU read grant -> no cpu_ack afterwards, all outputs 0, next request served normally.
